multicycle_control_unit: RTL and testbench

Main control FSM for the multicycle MIPS core. It sits on the driving side of the ALU interface: it sequences one instruction over 3–5 cycles and produces `ALUControl`, `ALUSrcA` and `ALUSrcB`. It consumes the ALU's `Zero` flag for branch resolution and drives every memory, IR, PC and register-file enable in the shared-memory datapath.

---
 rtl/multicycle_control_unit_if.sv | 34 +++
 rtl/multicycle_control_unit.sv | 169 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle for the multicycle MIPS core.
// The control unit is the master: it receives the instruction fields and Zero, and drives every datapath select and strobe.
interface multicycle_control_unit_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         Op;
  logic [5:0]         Funct;
  logic               Zero;
  logic               IorD;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [2:0]         ALUControl;
  logic [1:0]         PCSrc;
  logic               PCEn;
  logic               IllegalInstr;
  logic [STATE_W-1:0] State;

  modport master (
    input  Op, Funct, Zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUControl, PCSrc, PCEn, IllegalInstr, State
  );

  modport slave (
    output Op, Funct, Zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUControl, PCSrc, PCEn, IllegalInstr, State
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multicycle MIPS core.
// Moore outputs are registered alongside the state. Strobes are gated by RST, so a reset never leaves a write pending.
module multicycle_control_unit #(
  parameter int STATE_W = 4
) (
  input logic                        CLK,
  input logic                        RST,
  multicycle_control_unit_if.master  bus
);
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] nxt;
  ctrl_t              ctrl;

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b100;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b110;
      6'b011000: return 3'b101;
      default:   return 3'b011;
    endcase
  endfunction

  function automatic logic legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  // Output word the FSM presents while sitting in state st
  function automatic ctrl_t ctrl_for(input logic [STATE_W-1:0] st, input logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.alu_src_b   = 2'b01;
        c.alu_control = 3'b010;
        c.ir_write    = 1'b1;
        c.pc_write    = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b   = 2'b11;
        c.alu_control = 3'b010;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = 2'b10;
        c.alu_control = 3'b010;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = funct_alu(f);
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a   = 1'b1;
        c.alu_control = 3'b100;
        c.pc_src      = 2'b01;
        c.branch      = 1'b1;
      end
      S_JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH: nxt = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXECUTE;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JUMP;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR:  nxt = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   nxt = S_MEMWB;
      S_EXECUTE: nxt = S_ALUWB;
      S_ADDIEX:  nxt = S_ADDIWB;
      default:   nxt = S_FETCH;
    endcase
  end

  // Funct only matters when entering EXECUTE, i.e. it is sampled in DECODE while the IR is held
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_FETCH;
      ctrl  <= ctrl_for(S_FETCH, 6'b000000);
    end else begin
      state <= nxt;
      ctrl  <= ctrl_for(nxt, bus.Funct);
    end
  end

  assign bus.IorD         = ctrl.iord;
  assign bus.MemWrite     = ctrl.mem_write & RST;
  assign bus.IRWrite      = ctrl.ir_write & RST;
  assign bus.RegDst       = ctrl.reg_dst;
  assign bus.MemtoReg     = ctrl.mem_to_reg;
  assign bus.RegWrite     = ctrl.reg_write & RST;
  assign bus.ALUSrcA      = ctrl.alu_src_a;
  assign bus.ALUSrcB      = ctrl.alu_src_b;
  assign bus.ALUControl   = ctrl.alu_control;
  assign bus.PCSrc        = ctrl.pc_src;
  assign bus.PCEn         = RST & (ctrl.pc_write | (ctrl.branch & bus.Zero));
  assign bus.IllegalInstr = RST & (state == S_DECODE) & ~legal_op(bus.Op);
  assign bus.State        = state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: directed instruction sequences push hand-written expected output words,
// and a monitor pops one expected word per negative clock edge (or on an explicit mid-cycle sample).
module tb_multicycle_control_unit;
  logic CLK;
  logic RST;
  multicycle_control_unit_if #(.STATE_W(4)) bus ();

  multicycle_control_unit #(.STATE_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_bad = 0;
  string       name_q[$];
  logic [19:0] exp_q[$];
  event        sample_ev;

  // Packs {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUControl,PCSrc,PCEn,IllegalInstr,State}
  function automatic logic [19:0] v(input logic iord, input logic mw, input logic irw,
                                    input logic rd, input logic m2r, input logic rw,
                                    input logic sa, input logic [1:0] sb, input logic [2:0] ac,
                                    input logic [1:0] ps, input logic pcen, input logic ill,
                                    input logic [3:0] st);
    return {iord, mw, irw, rd, m2r, rw, sa, sb, ac, ps, pcen, ill, st};
  endfunction

  function automatic logic [19:0] actual();
    return {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
            bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.PCSrc, bus.PCEn, bus.IllegalInstr,
            bus.State};
  endfunction

  logic [19:0] RST_V, FETCH_V, DECODE_V, DECILL_V, MEMADR_V, MEMRD_V, MEMWB_V, MEMWR_V;
  logic [19:0] ALUWB_V, ADDIEX_V, ADDIWB_V, JUMP_V;

  initial begin
    RST_V    = v(0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0,4'd0);
    FETCH_V  = v(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0,4'd0);
    DECODE_V = v(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0,4'd1);
    DECILL_V = v(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,1,4'd1);
    MEMADR_V = v(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,4'd2);
    MEMRD_V  = v(1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,4'd3);
    MEMWB_V  = v(0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,0,4'd4);
    MEMWR_V  = v(1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,4'd5);
    ALUWB_V  = v(0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,0,4'd7);
    ADDIEX_V = v(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,4'd9);
    ADDIWB_V = v(0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,0,4'd10);
    JUMP_V   = v(0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,0,4'd11);
  end

  function automatic logic [19:0] exec_v(input logic [2:0] ac);
    return v(0,0,0,0,0,0,1,2'b00,ac,2'b00,0,0,4'd6);
  endfunction

  function automatic logic [19:0] branch_v(input logic z);
    return v(0,0,0,0,0,0,1,2'b00,3'b100,2'b01,z,0,4'd8);
  endfunction

  // Monitor: one expected word per sample point
  initial begin
    string       nm;
    logic [19:0] e;
    logic [19:0] a;
    forever begin
      @(negedge CLK or sample_ev);
      if (exp_q.size() > 0) begin
        nm = name_q.pop_front();
        e  = exp_q.pop_front();
        a  = actual();
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got %05h expected %05h", nm, a, e);
        end
      end
    end
  end

  task automatic push(input string n, input logic [19:0] e);
    name_q.push_back(n);
    exp_q.push_back(e);
  endtask

  task automatic step(input string n, input logic [19:0] e);
    push(n, e);
    @(posedge CLK);
    #1;
  endtask

  logic [5:0] funct_tab[7] = '{6'b100010, 6'b101010, 6'b011000, 6'b111111,
                               6'b100000, 6'b100100, 6'b100101};
  logic [2:0] alu_tab[7]   = '{3'b100, 3'b110, 3'b101, 3'b011,
                               3'b010, 3'b000, 3'b001};

  initial begin
    RST = 1'b0;
    bus.Op = 6'b100011;
    bus.Funct = 6'b000000;
    bus.Zero = 1'b0;
    @(posedge CLK);
    #1;
    step("reset0", RST_V);
    step("reset1", RST_V);
    step("reset2", RST_V);
    RST = 1'b1;

    step("lw_fetch",  FETCH_V);
    step("lw_decode", DECODE_V);
    step("lw_memadr", MEMADR_V);
    step("lw_memrd",  MEMRD_V);
    step("lw_memwb",  MEMWB_V);

    for (int i = 0; i < 7; i++) begin
      bus.Op = 6'b000000;
      bus.Funct = funct_tab[i];
      step("r_fetch",   FETCH_V);
      step("r_decode",  DECODE_V);
      step("r_execute", exec_v(alu_tab[i]));
      step("r_aluwb",   ALUWB_V);
    end

    bus.Op = 6'b001000;
    step("addi_fetch",  FETCH_V);
    step("addi_decode", DECODE_V);
    step("addi_ex",     ADDIEX_V);
    step("addi_wb",     ADDIWB_V);

    bus.Op = 6'b000100;
    bus.Zero = 1'b1;
    step("beq1_fetch",  FETCH_V);
    step("beq1_decode", DECODE_V);
    step("beq1_branch", branch_v(1'b1));
    bus.Zero = 1'b0;
    step("beq0_fetch",  FETCH_V);
    step("beq0_decode", DECODE_V);
    step("beq0_branch", branch_v(1'b0));

    bus.Op = 6'b000010;
    step("j_fetch",  FETCH_V);
    step("j_decode", DECODE_V);
    step("j_jump",   JUMP_V);

    bus.Op = 6'b111111;
    step("ill_fetch",  FETCH_V);
    step("ill_decode", DECILL_V);

    bus.Op = 6'b101011;
    step("sw_fetch",  FETCH_V);
    step("sw_decode", DECODE_V);
    step("sw_memadr", MEMADR_V);
    push("sw_memwr", MEMWR_V);
    @(negedge CLK);
    #1;
    RST = 1'b0;
    push("sw_abort", RST_V);
    #1;
    ->sample_ev;
    @(posedge CLK);
    #1;
    step("sw_abort_hold", RST_V);
    RST = 1'b1;

    force dut.state = 4'd13;
    #1;
    release dut.state;
    @(posedge CLK);
    #1;
    step("illegal_state_recover", FETCH_V);

    bus.Op = 6'b100011;
    step("lw2_decode", DECODE_V);
    step("lw2_memadr", MEMADR_V);

    repeat (2) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish by 50000");
    $fatal(1, "timeout");
  end
endmodule
